// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional checksum trailer is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int ISIZE                 = 16;
    localparam int MEM_SPACE             = 8;
    localparam int LOADER_BYTES_PER_WORD = 2;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        W_HI,
        W_LO,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader_cksum.sv
// 8-bit running byte sum; ok is high when sum plus the presented byte wraps to zero.
// Only instantiated when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader_cksum
    import imem_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] din,
    output logic       ok
);

    logic [7:0] sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sum <= 8'd0;
        else if (clr)
            sum <= 8'd0;
        else if (add)
            sum <= sum + din;
    end

    assign ok = ((sum + din) == 8'd0);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream to I-memory loader; holds the CPU in reset until the image is in.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing two's-complement checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ISIZE     = imem_loader_pkg::ISIZE,
    parameter int MEM_SPACE = imem_loader_pkg::MEM_SPACE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    output logic                 im_wen,
    output logic [MEM_SPACE-1:0] im_waddr,
    output logic [ISIZE-1:0]     im_wdata,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 err,
    output logic [MEM_SPACE:0]   word_count
);

    localparam logic [16:0] CAP = 17'd1 << MEM_SPACE;

    state_t         state, nstate;
    logic           xfer, start_ok, cnt_hit;
    logic [7:0]     len_hi, hi_q, lo_q;
    logic [15:0]    len_q, n_in;
    logic [MEM_SPACE:0] cnt_inc;

    assign xfer     = byte_valid && byte_ready;
    assign start_ok = start && (state inside {IDLE, DONE, ERR});
    assign n_in     = {len_hi, byte_data};
    assign cnt_inc  = word_count + {{MEM_SPACE{1'b0}}, 1'b1};
    assign cnt_hit  = ({{(15-MEM_SPACE){1'b0}}, cnt_inc} == len_q);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic cks_ok;

    imem_loader_cksum u_cksum (
        .clk (clk),
        .rst (rst),
        .clr (start_ok),
        .add (xfer),
        .din (byte_data),
        .ok  (cks_ok)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE, DONE, ERR: if (start) nstate = LEN_HI;
            LEN_HI:          if (xfer) nstate = LEN_LO;
            LEN_LO: if (xfer) begin
                if (n_in == 16'd0)
`ifdef IMEM_LOADER_CHECKSUM_EN
                    nstate = CHK;
`else
                    nstate = DONE;
`endif
                else if ({1'b0, n_in} > CAP)
                    nstate = ERR;
                else
                    nstate = W_HI;
            end
            W_HI:  if (xfer) nstate = W_LO;
            W_LO:  if (xfer) nstate = WRITE;
            WRITE: begin
                if (cnt_hit)
`ifdef IMEM_LOADER_CHECKSUM_EN
                    nstate = CHK;
`else
                    nstate = DONE;
`endif
                else
                    nstate = W_HI;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: if (xfer) nstate = cks_ok ? DONE : ERR;
`endif
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        im_wen     = 1'b0;
        case (state)
            LEN_HI, LEN_LO, W_HI, W_LO, CHK: byte_ready = 1'b1;
            WRITE:                           im_wen     = 1'b1;
            default: ;
        endcase
    end

    // Status flags are registered off nstate so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            cpu_hold <= (nstate != DONE);
            done     <= (nstate == DONE);
            err      <= (nstate == ERR);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_hi     <= 8'd0;
            len_q      <= 16'd0;
            hi_q       <= 8'd0;
            lo_q       <= 8'd0;
            word_count <= '0;
        end else begin
            if (start_ok)
                word_count <= '0;
            else if (state == WRITE)
                word_count <= cnt_inc;
            if (xfer && state == LEN_HI) len_hi <= byte_data;
            if (xfer && state == LEN_LO) len_q  <= n_in;
            if (xfer && state == W_HI)   hi_q   <= byte_data;
            if (xfer && state == W_LO)   lo_q   <= byte_data;
        end
    end

    assign im_waddr = word_count[MEM_SPACE-1:0];
    assign im_wdata = {hi_q, lo_q};

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as bytes are driven, popped on im_wen.
// Checksum cases run when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst, start, byte_valid, byte_ready;
    logic [7:0]  byte_data;
    logic        im_wen, cpu_hold, done, err;
    logic [7:0]  im_waddr;
    logic [15:0] im_wdata;
    logic [8:0]  word_count;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] bq[$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         wen_cnt = 0;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_wen     (im_wen),
        .im_waddr   (im_waddr),
        .im_wdata   (im_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (im_wen === 1'b1) begin
            wen_cnt++;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(im_waddr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(im_waddr), 32'(e.a));
                check("wr_data", 32'(im_wdata), 32'(e.d));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("byte_accept", 32'(byte_ready), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    // Drains bq; with add_cks the two's-complement checksum is appended when the feature is on.
    task automatic send_stream(input bit gap, input bit add_cks);
        logic [7:0] sum = 8'd0;
        while (bq.size() > 0) begin
            logic [7:0] b;
            b = bq.pop_front();
            sum += b;
            send_byte(b, gap);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (add_cks) send_byte(8'd0 - sum, gap);
`else
        if (add_cks) sum = 8'd0;
`endif
    endtask

    task automatic wait_end();
        int t = 0;
        while (done !== 1'b1 && err !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic push_word(input logic [7:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
        bq.push_back(d[15:8]);
        bq.push_back(d[7:0]);
    endtask

    task automatic basic_load(input bit gap, input string tag);
        pulse_start();
        bq = {8'h00, 8'h02};
        push_word(8'd0, 16'hA123);
        push_word(8'd1, 16'hB456);
        send_stream(gap, 1'b1);
        wait_end();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_count"}, 32'(word_count), 32'd2);
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int w0;
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_hold",  32'(cpu_hold),   32'd1);
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_wen",   32'(im_wen),     32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_err",   32'(err),        32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_addr",  32'(im_waddr),   32'd0);
        check("rst_data",  32'(im_wdata),   32'd0);

        rst = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        repeat (4) @(negedge clk);
        check("idle_ready", 32'(byte_ready), 32'd0);
        check("idle_hold",  32'(cpu_hold),   32'd1);
        check("idle_done",  32'(done),       32'd0);
        byte_valid = 1'b0;

        basic_load(1'b0, "back2back");
        basic_load(1'b1, "toggle");

        // Oversize length aborts right after LEN_LO
        pulse_start();
        check("restart_hold", 32'(cpu_hold), 32'd1);
        w0 = wen_cnt;
        bq = {8'h01, 8'h01};
        send_stream(1'b0, 1'b0);
        @(negedge clk);
        check("big_err",  32'(err),      32'd1);
        check("big_hold", 32'(cpu_hold), 32'd1);
        check("big_done", 32'(done),     32'd0);
        check("big_nowr", 32'(wen_cnt - w0), 32'd0);
        pulse_start();
        bq = {8'h00, 8'h00};
        send_stream(1'b0, 1'b1);
        wait_end();
        check("zero_done",  32'(done),       32'd1);
        check("zero_err",   32'(err),        32'd0);
        check("zero_count", 32'(word_count), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_start();
        bq = {8'h00, 8'h01};
        push_word(8'd0, 16'h1234);
        bq.push_back(8'hB9);
        send_stream(1'b0, 1'b0);
        wait_end();
        check("cks_good_done", 32'(done), 32'd1);
        pulse_start();
        bq = {8'h00, 8'h01};
        push_word(8'd0, 16'h1234);
        bq.push_back(8'hB8);
        send_stream(1'b0, 1'b0);
        wait_end();
        check("cks_bad_err",  32'(err),  32'd1);
        check("cks_bad_done", 32'(done), 32'd0);
        check("cks_bad_drain", 32'(exp_q.size()), 32'd0);
`endif

        // Full capacity: last write lands at the top address, count does not wrap
        pulse_start();
        bq = {8'h01, 8'h00};
        for (int i = 0; i < 256; i++)
            push_word(8'(i), 16'(i * 16'h0101) ^ 16'h3C5A);
        send_stream(1'b0, 1'b1);
        wait_end();
        check("full_done",  32'(done),       32'd1);
        check("full_count", 32'(word_count), 32'd256);
        check("full_drain", 32'(exp_q.size()), 32'd0);

        // Async reset in the middle of word 3
        pulse_start();
        bq = {8'h00, 8'h05};
        push_word(8'd0, 16'h1111);
        push_word(8'd1, 16'h2222);
        bq.push_back(8'h33);
        send_stream(1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_hold",  32'(cpu_hold),   32'd1);
        check("arst_ready", 32'(byte_ready), 32'd0);
        check("arst_wen",   32'(im_wen),     32'd0);
        check("arst_count", 32'(word_count), 32'd0);
        check("arst_addr",  32'(im_waddr),   32'd0);
        check("arst_data",  32'(im_wdata),   32'd0);
        check("arst_done",  32'(done),       32'd0);
        check("arst_drain", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        bq = {8'h00, 8'h01};
        push_word(8'd0, 16'hCAFE);
        send_stream(1'b0, 1'b1);
        wait_end();
        check("reload_done",  32'(done),       32'd1);
        check("reload_count", 32'(word_count), 32'd1);
        check("reload_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
